// File: rtl/aes_dec_iter_ctrl_if.sv
// Block-in / plaintext-out handshake bundle for the iterative AES-128 decryptor.
// master drives ciphertext and takes plaintext; slave is the sequencer.
interface aes_dec_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;

    modport master (
        output in_valid, ct_in, out_ready,
        input  in_ready, out_valid, pt_out
    );

    modport slave (
        input  in_valid, ct_in, out_ready,
        output in_ready, out_valid, pt_out
    );
endinterface

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 inverse cipher, one round per clock over a shared inverse round.
// Optional block counter enabled by defining AES_DEC_BLK_COUNT_EN.
module aes_dec_iter_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    aes_dec_iter_ctrl_if.slave   bus,
    output logic [3:0]           key_addr,
    input  logic [127:0]         round_key,
    output logic                 busy,
    output logic [15:0]          blk_count
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    state_t       state;
    logic [127:0] st;
    logic [3:0]   rnd;
    logic [127:0] pt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [127:0] round_xor(input logic [127:0] a, input logic [127:0] k);
        return a ^ k;
    endfunction

    function automatic logic [127:0] inverse_sub_bytes_r(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv_sbox(v[8*i +: 8]);
        return o;
    endfunction

    // Byte i sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] inverse_shift_rows(input logic [127:0] v);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = v[127-8*(r+4*((c+4-r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inverse_mix_columns(input logic [127:0] v);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = v[127-32*c -: 8];
            a1 = v[119-32*c -: 8];
            a2 = v[111-32*c -: 8];
            a3 = v[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                             ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                             ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                             ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    function automatic logic [127:0] inverse_round(input logic [127:0] s, input logic [127:0] k);
        return inverse_sub_bytes_r(inverse_shift_rows(inverse_mix_columns(round_xor(s, k))));
    endfunction

    always_comb begin
        key_addr = 4'd0;
        unique case (state)
            IDLE:    key_addr = 4'd10;
            ROUND:   key_addr = rnd;
            default: key_addr = 4'd0;
        endcase
    end

    // Entry step applies key 10 and undoes the last (mix-less) forward round.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            st          <= '0;
            rnd         <= '0;
            pt_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        st         <= inverse_sub_bytes_r(
                                          inverse_shift_rows(round_xor(bus.ct_in, round_key)));
                        rnd        <= 4'd9;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ROUND;
                    end
                end
                ROUND: begin
                    st <= inverse_round(st, round_key);
                    if (rnd == 4'd1) state <= FINAL;
                    else             rnd   <= rnd - 4'd1;
                end
                FINAL: begin
                    pt_q        <= st ^ round_key;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pt_out    = pt_q;
    assign busy          = busy_q;

`ifdef AES_DEC_BLK_COUNT_EN
    logic [15:0] blk_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            blk_cnt_q <= '0;
        else if (state == DONE && bus.out_ready)
            blk_cnt_q <= blk_cnt_q + 16'd1;
    end

    assign blk_count = blk_cnt_q;
`else
    assign blk_count = '0;
`endif

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: forward-cipher reference model produces ciphertexts,
// directed handshake/reset/backpressure steps plus randomized keys and blocks.
module tb_aes_dec_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   key_addr;
    logic [127:0] round_key;
    logic         busy;
    logic [15:0]  blk_count;

    aes_dec_iter_ctrl_if bus();

    aes_dec_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .key_addr  (key_addr),
        .round_key (round_key),
        .busy      (busy),
        .blk_count (blk_count)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

    logic [127:0] rk [0:10];
    logic [7:0]   sbox [0:255];

    assign round_key = (key_addr <= 4'd10) ? rk[key_addr] : '0;

    int checks   = 0;
    int failures = 0;

    int           cyc = 0;
    int           acc_cyc [$];
    logic [127:0] got [$];

    always @(posedge clk) begin
        cyc++;
        if (!rst && bus.in_valid && bus.in_ready) acc_cyc.push_back(cyc);
        if (!rst && bus.out_valid && bus.out_ready) got.push_back(bus.pt_out);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Forward S-box: brute-force inverse then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t ^= {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[q+4*c] = s[q+4*((c+q)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r != 10) begin
                    s[4*c]   = gmul(t[4*c],2) ^ gmul(t[4*c+1],3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],2) ^ gmul(t[4*c+2],3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],2) ^ gmul(t[4*c+3],3);
                    s[4*c+3] = gmul(t[4*c],3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],2);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts and ends at a negedge in IDLE; checks cycle-accurate progress.
    task automatic do_block(input logic [127:0] ct, input logic [127:0] exp,
                            input int stall, input bit poke, input string tag);
        int n0 = acc_cyc.size();
        int g0 = got.size();
        bit ok_rdy = 1, ok_key = 1, ok_busy = 1;
        logic [127:0] held;
        for (int i = 0; i < 30 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        chk({tag, "_idle_ready"}, bus.in_ready, 1'b1);
        chk({tag, "_idle_key"}, key_addr, 4'd10);
        bus.ct_in     = ct;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ct_in    = rnd128();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ok_rdy = 0;
            if (k <= 10) begin
                if (key_addr !== 4'(k <= 9 ? 10 - k : 0)) ok_key = 0;
                if (busy !== 1'b1 || bus.out_valid !== 1'b0) ok_busy = 0;
            end else if (busy !== 1'b0) ok_busy = 0;
            if (poke && k == 4) begin
                bus.in_valid = 1'b1;
                bus.ct_in    = rnd128();
            end
            if (poke && k == 5) bus.in_valid = 1'b0;
        end
        chk({tag, "_ready_low"}, ok_rdy, 1'b1);
        chk({tag, "_key_seq"}, ok_key, 1'b1);
        chk({tag, "_busy"}, ok_busy, 1'b1);
        chk({tag, "_valid_c11"}, bus.out_valid, 1'b1);
        chk({tag, "_pt"}, bus.pt_out, exp);
        if (stall > 0) begin
            bit ok_hold = 1;
            held = bus.pt_out;
            bus.in_valid = 1'b1;
            bus.ct_in    = rnd128();
            for (int s = 1; s <= stall; s++) begin
                @(negedge clk);
                if (bus.pt_out !== held || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
                    ok_hold = 0;
            end
            chk({tag, "_hold"}, ok_hold, 1'b1);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_back_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
        chk({tag, "_accepts"}, acc_cyc.size() - n0, 1);
        chk({tag, "_outputs"}, got.size() - g0, 1);
    endtask

    initial begin
        logic [127:0] p1, p2, c1, c2;
        int n0, g0;
        bit ok;
        build_sbox();
        bus.in_valid  = 1'b0;
        bus.ct_in     = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.in_ready, 1'b1);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pt", bus.pt_out, '0);
        chk("rst_key", key_addr, 4'd10);
        chk("rst_cnt", blk_count, '0);

        expand(FIPS_KEY);
        do_block(FIPS_CT, FIPS_PT, 0, 1'b0, "fips");

        // Back-to-back with in_valid held high across both blocks.
        p1 = rnd128();
        p2 = rnd128();
        c1 = encrypt(p1);
        c2 = encrypt(p2);
        n0 = acc_cyc.size();
        g0 = got.size();
        ok = 1;
        bus.ct_in    = c1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.ct_in = c2;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ok = 0;
        end
        @(negedge clk);
        chk("b2b_ready_c12", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ct_in    = rnd128();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ok = 0;
        end
        @(negedge clk);
        chk("b2b_ready_low", ok, 1'b1);
        chk("b2b_accepts", acc_cyc.size() - n0, 2);
        if (acc_cyc.size() - n0 == 2)
            chk("b2b_spacing", acc_cyc[n0+1] - acc_cyc[n0], 12);
        chk("b2b_outputs", got.size() - g0, 2);
        if (got.size() - g0 == 2) begin
            chk("b2b_pt1", got[g0], p1);
            chk("b2b_pt2", got[g0+1], p2);
        end

        p1 = rnd128();
        do_block(encrypt(p1), p1, 5, 1'b0, "stall");
        p1 = rnd128();
        do_block(encrypt(p1), p1, 0, 1'b1, "poke");

        // Abort a block with reset in cycle 5.
        g0 = got.size();
        bus.ct_in    = FIPS_CT ^ 128'h1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_idle", {bus.in_ready, bus.out_valid, busy}, 3'b100);
        chk("abort_pt", bus.pt_out, '0);
        chk("abort_key", key_addr, 4'd10);
        chk("abort_cnt", blk_count, '0);
        ok = 1;
        repeat (14) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ok = 0;
        end
        chk("abort_no_out", {ok, 16'(got.size() - g0)}, {1'b1, 16'd0});
        do_block(FIPS_CT, FIPS_PT, 0, 1'b0, "fips_after_rst");

        for (int i = 0; i < 6; i++) begin
            expand(rnd128());
            p1 = rnd128();
            do_block(encrypt(p1), p1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", i));
        end

`ifdef AES_DEC_BLK_COUNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            p1 = rnd128();
            do_block(encrypt(p1), p1, 0, 1'b0, $sformatf("cnt%0d", i));
        end
        chk("cnt_three", blk_count, 16'd3);
        force dut.blk_cnt_q = 16'hffff;
        @(negedge clk);
        release dut.blk_cnt_q;
        @(negedge clk);
        chk("cnt_preload", blk_count, 16'hffff);
        p1 = rnd128();
        do_block(encrypt(p1), p1, 0, 1'b0, "cnt_wrap_blk");
        chk("cnt_wrap", blk_count, 16'h0000);
`else
        chk("cnt_disabled", blk_count, 16'h0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
